// File: rtl/ram2_responder_pkg.sv
// Shared definitions for the RAM2 SRAM stand-in: FSM encoding and pin polarity.
package ram2_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic ACTIVE_LOW = 1'b0;

    function automatic logic pin_active(input logic pin);
        return pin == ACTIVE_LOW;
    endfunction

endpackage

// File: rtl/ram2_pin_sync.sv
// STAGES-deep flop chain that brings asynchronous Ram2 pins into the clk domain.
module ram2_pin_sync
    import ram2_responder_pkg::*;
#(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d_i;
        for (int unsigned i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ram2_responder.sv
// Device-side model of the RAM2 async SRAM: oversamples the pin bundle, serves
// reads while OE/EN are low and commits writes when WE is released.
module ram2_responder
    import ram2_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH_W     = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  Ram2Addr_i,
    input  logic [DATA_W-1:0]  Ram2Data_i,
    output logic [DATA_W-1:0]  Ram2Data_o,
    output logic               Ram2Data_oe_o,
    input  logic               Ram2OE_i,
    input  logic               Ram2WE_i,
    input  logic               Ram2EN_i,
    output logic [15:0]        wr_count_o,
    output logic               conflict_o,
    input  logic [DEPTH_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]  dbg_data_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_W;

    logic [ADDR_W-1:0]  s_addr;
    logic [DATA_W-1:0]  s_data;
    logic [2:0]         s_ctrl;
    logic               sel, oe_act, we_act;
    logic [DEPTH_W-1:0] s_idx;
    logic               unused_addr_hi;

    ram2_pin_sync #(.WIDTH(ADDR_W), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_addr (
        .clk(clk), .rst(rst), .d_i(Ram2Addr_i), .q_o(s_addr)
    );

    ram2_pin_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_data (
        .clk(clk), .rst(rst), .d_i(Ram2Data_i), .q_o(s_data)
    );

    ram2_pin_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b111)) u_sync_ctrl (
        .clk(clk), .rst(rst), .d_i({Ram2OE_i, Ram2WE_i, Ram2EN_i}), .q_o(s_ctrl)
    );

    assign oe_act = pin_active(s_ctrl[2]);
    assign we_act = pin_active(s_ctrl[1]);
    assign sel    = pin_active(s_ctrl[0]);
    // Upper address pins are deliberately ignored so the array aliases.
    assign s_idx          = s_addr[DEPTH_W-1:0];
    assign unused_addr_hi = ^s_addr[ADDR_W-1:DEPTH_W];

    logic [DATA_W-1:0]  mem [DEPTH];

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               oe_q, oe_d;
    logic [15:0]        wr_count_q, wr_count_d;
    logic               conflict_q, conflict_d;
    logic [DEPTH_W-1:0] lat_idx_q, lat_idx_d;
    logic [DATA_W-1:0]  lat_data_q, lat_data_d;
    logic [DATA_W-1:0]  dbg_q, dbg_d;
    logic               mem_we;
    logic [DATA_W-1:0]  rd_word;

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        oe_d       = oe_q;
        wr_count_d = wr_count_q;
        conflict_d = conflict_q;
        lat_idx_d  = lat_idx_q;
        lat_data_d = lat_data_q;
        mem_we     = 1'b0;
        rd_word    = mem[s_idx];
        dbg_d      = mem[dbg_addr_i];

        case (state_q)
            ST_IDLE: begin
                oe_d = 1'b0;
                if (sel && we_act) begin
                    state_d    = ST_WRITE;
                    lat_idx_d  = s_idx;
                    lat_data_d = s_data;
                    if (oe_act) conflict_d = 1'b1;
                end else if (sel && oe_act) begin
                    state_d = ST_READ;
                    rdata_d = rd_word;
                    oe_d    = 1'b1;
                end
            end
            ST_READ: begin
                rdata_d = rd_word;
                if (sel && we_act) begin
                    state_d    = ST_WRITE;
                    oe_d       = 1'b0;
                    conflict_d = 1'b1;
                    lat_idx_d  = s_idx;
                    lat_data_d = s_data;
                end else if (!oe_act || !sel) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            end
            ST_WRITE: begin
                oe_d = 1'b0;
                if (oe_act) conflict_d = 1'b1;
                if (!we_act) begin
                    state_d = ST_IDLE;
                    if (sel) begin
                        mem_we     = 1'b1;
                        wr_count_d = wr_count_q + 16'd1;
                    end
                end else if (!sel) begin
                    state_d = ST_IDLE;
                end else begin
                    lat_idx_d  = s_idx;
                    lat_data_d = s_data;
                end
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rdata_q    <= '0;
            oe_q       <= 1'b0;
            wr_count_q <= '0;
            conflict_q <= 1'b0;
            lat_idx_q  <= '0;
            lat_data_q <= '0;
            dbg_q      <= '0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            oe_q       <= oe_d;
            wr_count_q <= wr_count_d;
            conflict_q <= conflict_d;
            lat_idx_q  <= lat_idx_d;
            lat_data_q <= lat_data_d;
            dbg_q      <= dbg_d;
        end
    end

    // Gated by rst so a commit coinciding with reset is dropped with the pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[lat_idx_q] <= lat_data_q;
        end
    end

    assign Ram2Data_o    = rdata_q;
    assign Ram2Data_oe_o = oe_q;
    assign wr_count_o    = wr_count_q;
    assign conflict_o    = conflict_q;
    assign dbg_data_o    = dbg_q;

endmodule

// File: doc/ram2_responder.md
Name: ram2_responder

Overview:
- Synthesizable on-chip stand-in for the external RAM2 asynchronous SRAM.
- Sits on the device side of the Ram2 pin bundle and answers the CPU-side RAM2 controller: serves reads while OE/EN are low and commits writes on the WE rising edge.
- Used for FPGA self-test and simulation without the physical chip.
- Clocked by `clk`, which must run at least 4x the CPU clock so that pin-level OE/WE pulses are oversampled.

Parameters:
- ADDR_W, 18, width of the Ram2 address pins.
- DATA_W, 16, width of the data bus.
- DEPTH_W, 12, implemented address bits; storage is 2^DEPTH_W words.
- SYNC_STAGES, 2, flop stages on every pin input.

Ports:
- clk  in  1  responder clock (oversampling clock).
- rst  in  1  synchronous, active-high reset.
- Ram2Addr_i  in  ADDR_W  address pins from the controller.
- Ram2Data_i  in  DATA_W  data bus value driven by the controller.
- Ram2Data_o  out  DATA_W  read data toward the bus.
- Ram2Data_oe_o  out  1  1 = responder drives the bus; the top level builds the tristate.
- Ram2OE_i  in  1  output enable, active low.
- Ram2WE_i  in  1  write enable, active low.
- Ram2EN_i  in  1  chip enable, active low.
- wr_count_o  out  16  number of committed writes.
- conflict_o  out  1  sticky flag: OE and WE were seen low together.
- dbg_addr_i  in  DEPTH_W  backdoor read address.
- dbg_data_o  out  DATA_W  backdoor read data, 1-cycle latency.

Behaviour:
- **Reset** (rst=1 at a clk edge): Ram2Data_o=0, Ram2Data_oe_o=0, wr_count_o=0, conflict_o=0, dbg_data_o=0, state=IDLE, sync flops cleared to their idle values (OE/WE/EN=1, addr/data=0).
  - Memory contents are not reset.
  - Reset mid-write discards the pending write.
- **Input sampling:** every pin passes through SYNC_STAGES flops. All decisions use the synchronized values s_addr, s_data, s_OE, s_WE, s_EN.
  - Chip is selected when s_EN=0.
  - Word index = s_addr[DEPTH_W-1:0]; upper address bits are ignored (aliasing wrap).
- **FSM states:** IDLE, READ, WRITE.
- **IDLE:**
  - sel & s_WE=0 -> WRITE; latch addr/data.
  - else sel & s_OE=0 -> READ; at the same edge Ram2Data_o<=mem[idx] and Ram2Data_oe_o<=1.
  - else stay in IDLE with Ram2Data_oe_o=0.
- **READ:**
  - Every cycle Ram2Data_o<=mem[idx], so an address change appears 1 clk after it is synchronized.
  - Exit to IDLE when s_OE=1 or s_EN=1; Ram2Data_oe_o<=0 at that edge.
  - s_WE=0 while in READ -> WRITE, Ram2Data_oe_o<=0, conflict_o<=1.
- **WRITE:**
  - Ram2Data_oe_o held 0.
  - Every cycle with s_WE=0 re-latch addr/data; the last value before release wins.
  - s_WE=1 with sel -> commit mem[latched idx]<=latched data, wr_count_o+=1 (wraps 0xFFFF->0), go to IDLE.
  - s_EN=1 while s_WE=0 -> abort with no commit, go to IDLE.
  - s_OE=0 while in WRITE -> conflict_o<=1.
- **Simultaneous OE=0 and WE=0:** WE has priority and conflict_o sets. conflict_o clears only on reset.
- **Read latency:** pin OE falls at edge k; Ram2Data_oe_o=1 with valid data after edge k+SYNC_STAGES+1.
- **Read-after-write:** a READ entered on the edge after a commit returns the new data (write-first).
- **dbg port:** dbg_data_o<=mem[dbg_addr_i] every cycle. This second read port does not interfere with the FSM.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2).
  - Pin polarity constants (ACTIVE_LOW=1'b0).
- Natural sub-module: ram2_pin_sync, a SYNC_STAGES-deep synchronizer, instanced per pin group with a reset-value parameter.
- Memory is an inferred dual-port array inside the top module.

Test Plan:
- **Reset state:** after reset, drive EN=0, WE=0, addr=0x00005, data=0xBEEF for 4 clk, then WE=1 -> wr_count_o=1 and dbg_addr_i=5 gives dbg_data_o=0xBEEF.
- **Read latency:** with mem[5]=0xBEEF, set EN=0, OE=0, addr=5 at edge k -> Ram2Data_oe_o=1 and Ram2Data_o=0xBEEF exactly after edge k+3; change addr to 6 (mem[6]=0x1234) -> data 0x1234 three edges later; OE=1 -> oe_o drops 3 edges later.
- **Aliasing:** write 0xA5A5 to addr 0x3F00A -> dbg read of index 0x00A returns 0xA5A5.
- **Abort:** EN rises while WE is low (addr 7, data 0x5555), then WE rises -> mem[7] unchanged, wr_count_o unchanged.
- **Conflict:** OE and WE both low at addr 9, data 0x0F0F -> Ram2Data_oe_o stays 0, write commits, conflict_o=1 until rst.
- **Reset mid-write and counter wrap:** assert rst while WE is low -> no commit, wr_count_o=0. Separately, 65536 writes -> wr_count_o=0.
